// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: latches ALU result, resolves branches,
// and lane-aligns store data with byte strobes and alignment faults.
module ex_mem_stage #(
    parameter int DATA_W     = 32,
    parameter int BUBBLE_CTL = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              InValid,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic              Zero,
    input  logic [2:0]        BranchType,
    input  logic [DATA_W-1:0] PCPlus4,
    input  logic [DATA_W-1:0] SignExtImm,
    input  logic [DATA_W-1:0] StoreData,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [1:0]        MemSize,
    input  logic              RegWrite,
    input  logic [4:0]        WriteReg,
    output logic              OutValid,
    output logic [DATA_W-1:0] OutALUResult,
    output logic              BranchTaken,
    output logic [DATA_W-1:0] BranchTarget,
    output logic [DATA_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic [3:0]        MemByteEn,
    output logic              OutMemWrite,
    output logic              OutMemRead,
    output logic [1:0]        OutMemSize,
    output logic              OutRegWrite,
    output logic [4:0]        OutWriteReg,
    output logic              Misaligned
);

    localparam logic BUB = (BUBBLE_CTL != 0);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic              taken_q, taken_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              mwr_q, mwr_d;
    logic              mrd_q, mrd_d;
    logic [1:0]        size_q, size_d;
    logic              rwr_q, rwr_d;
    logic [4:0]        wreg_q, wreg_d;
    logic              mis_q, mis_d;

    logic              taken_c;
    logic              align_ok_c;
    logic              fault_c;
    logic [3:0]        lane_c;
    logic [DATA_W-1:0] wdata_c;
    logic [1:0]        ofs_c;

    // Range branches: ALU drives 1 when the condition holds, so Zero=0 is taken.
    always_comb begin
        taken_c = 1'b0;
        case (BranchType)
            3'd1:    taken_c = Zero;
            3'd2,
            3'd3,
            3'd4,
            3'd5,
            3'd6:    taken_c = ~Zero;
            default: taken_c = 1'b0;
        endcase
    end

    assign ofs_c = ALUResult[1:0];

    always_comb begin
        align_ok_c = 1'b0;
        lane_c     = 4'b0000;
        wdata_c    = StoreData;
        case (MemSize)
            2'd0: begin
                align_ok_c = (ofs_c == 2'd0);
                lane_c     = 4'b1111;
                wdata_c    = StoreData;
            end
            2'd1: begin
                align_ok_c = ~ofs_c[0];
                lane_c     = 4'b0011 << ofs_c;
                wdata_c    = {2{StoreData[15:0]}};
            end
            2'd2: begin
                align_ok_c = 1'b1;
                lane_c     = 4'b0001 << ofs_c;
                wdata_c    = {4{StoreData[7:0]}};
            end
            default: begin
                align_ok_c = 1'b0;
                lane_c     = 4'b0000;
            end
        endcase
    end

    assign fault_c = (MemWrite | MemRead) & ~align_ok_c;

    always_comb begin
        valid_d  = valid_q;
        alu_d    = alu_q;
        taken_d  = taken_q;
        target_d = target_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        mwr_d    = mwr_q;
        mrd_d    = mrd_q;
        size_d   = size_q;
        rwr_d    = rwr_q;
        wreg_d   = wreg_q;
        mis_d    = mis_q;
        if (Flush || (!Stall && !InValid)) begin
            valid_d = BUB;
            taken_d = BUB;
            be_d    = {4{BUB}};
            mwr_d   = BUB;
            mrd_d   = BUB;
            rwr_d   = BUB;
            mis_d   = BUB;
        end else if (!Stall) begin
            valid_d  = 1'b1;
            alu_d    = ALUResult;
            taken_d  = taken_c;
            target_d = PCPlus4 + (SignExtImm << 2);
            wdata_d  = wdata_c;
            be_d     = (MemWrite && !fault_c) ? lane_c : 4'b0000;
            mwr_d    = MemWrite & ~fault_c;
            mrd_d    = MemRead & ~fault_c;
            size_d   = MemSize;
            rwr_d    = RegWrite;
            wreg_d   = WriteReg;
            mis_d    = fault_c;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q  <= BUB;
            alu_q    <= '0;
            taken_q  <= BUB;
            target_q <= '0;
            wdata_q  <= '0;
            be_q     <= {4{BUB}};
            mwr_q    <= BUB;
            mrd_q    <= BUB;
            size_q   <= '0;
            rwr_q    <= BUB;
            wreg_q   <= '0;
            mis_q    <= BUB;
        end else begin
            valid_q  <= valid_d;
            alu_q    <= alu_d;
            taken_q  <= taken_d;
            target_q <= target_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            mwr_q    <= mwr_d;
            mrd_q    <= mrd_d;
            size_q   <= size_d;
            rwr_q    <= rwr_d;
            wreg_q   <= wreg_d;
            mis_q    <= mis_d;
        end
    end

    assign OutValid     = valid_q;
    assign OutALUResult = alu_q;
    assign BranchTaken  = taken_q;
    assign BranchTarget = target_q;
    assign MemAddr      = {alu_q[DATA_W-1:2], 2'b00};
    assign MemWData     = wdata_q;
    assign MemByteEn    = be_q;
    assign OutMemWrite  = mwr_q;
    assign OutMemRead   = mrd_q;
    assign OutMemSize   = size_q;
    assign OutRegWrite  = rwr_q;
    assign OutWriteReg  = wreg_q;
    assign Misaligned   = mis_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed cases then random traffic
// against an arithmetic reference model.
module tb_ex_mem_stage;

    logic        Clk = 1'b0;
    logic        Reset, Stall, Flush, InValid;
    logic [31:0] ALUResult, PCPlus4, SignExtImm, StoreData;
    logic        Zero, MemWrite, MemRead, RegWrite;
    logic [2:0]  BranchType;
    logic [1:0]  MemSize;
    logic [4:0]  WriteReg;

    logic        OutValid, BranchTaken, OutMemWrite, OutMemRead;
    logic        OutRegWrite, Misaligned;
    logic [31:0] OutALUResult, BranchTarget, MemAddr, MemWData;
    logic [3:0]  MemByteEn;
    logic [1:0]  OutMemSize;
    logic [4:0]  OutWriteReg;

    int ncmp = 0;
    int nerr = 0;

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic        taken;
        logic [31:0] target;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        mw;
        logic        mr;
        logic [1:0]  size;
        logic        rw;
        logic [4:0]  wreg;
        logic        mis;
    } exp_t;

    exp_t exp_s;
    bit   dknown;
    bit   wknown;

    ex_mem_stage #(.DATA_W(32), .BUBBLE_CTL(0)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .InValid(InValid), .ALUResult(ALUResult), .Zero(Zero),
        .BranchType(BranchType), .PCPlus4(PCPlus4),
        .SignExtImm(SignExtImm), .StoreData(StoreData),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemSize(MemSize),
        .RegWrite(RegWrite), .WriteReg(WriteReg),
        .OutValid(OutValid), .OutALUResult(OutALUResult),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemByteEn(MemByteEn),
        .OutMemWrite(OutMemWrite), .OutMemRead(OutMemRead),
        .OutMemSize(OutMemSize), .OutRegWrite(OutRegWrite),
        .OutWriteReg(OutWriteReg), .Misaligned(Misaligned)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference behaviour written from the access-size / offset rules.
    task automatic model_edge();
        int nbytes;
        int off;
        bit fault;
        if (Reset) begin
            exp_s  = '{default: '0};
            dknown = 1;
            wknown = 1;
        end else if (Flush || (!Stall && !InValid)) begin
            exp_s.valid = 0;
            exp_s.taken = 0;
            exp_s.mw    = 0;
            exp_s.mr    = 0;
            exp_s.rw    = 0;
            exp_s.mis   = 0;
            exp_s.be    = 4'b0000;
            dknown      = 0;
            wknown      = 0;
        end else if (!Stall) begin
            nbytes = (MemSize == 0) ? 4 : (MemSize == 1) ? 2 :
                     (MemSize == 2) ? 1 : 0;
            off    = int'(ALUResult % 4);
            fault  = (MemWrite || MemRead) &&
                     (nbytes == 0 || (off % nbytes) != 0);
            exp_s.valid  = 1;
            exp_s.alu    = ALUResult;
            exp_s.taken  = (BranchType == 1) ? Zero :
                           (BranchType >= 2 && BranchType <= 6) ? !Zero : 1'b0;
            exp_s.target = PCPlus4 + SignExtImm * 32'd4;
            exp_s.addr   = ALUResult - 32'(off);
            for (int i = 0; i < 4; i++)
                exp_s.be[i] = MemWrite && !fault && i >= off && i < off + nbytes;
            if (nbytes == 4)      exp_s.wdata = StoreData;
            else if (nbytes == 2) exp_s.wdata = (StoreData % 65536) * 32'h0001_0001;
            else                  exp_s.wdata = (StoreData % 256) * 32'h0101_0101;
            exp_s.mw   = MemWrite && !fault;
            exp_s.mr   = MemRead && !fault;
            exp_s.size = MemSize;
            exp_s.rw   = RegWrite;
            exp_s.wreg = WriteReg;
            exp_s.mis  = fault;
            dknown     = 1;
            wknown     = MemWrite && !fault;
        end
    endtask

    task automatic check_all();
        chk("OutValid",    32'(OutValid),    32'(exp_s.valid));
        chk("BranchTaken", 32'(BranchTaken), 32'(exp_s.taken));
        chk("MemByteEn",   32'(MemByteEn),   32'(exp_s.be));
        chk("OutMemWrite", 32'(OutMemWrite), 32'(exp_s.mw));
        chk("OutMemRead",  32'(OutMemRead),  32'(exp_s.mr));
        chk("OutRegWrite", 32'(OutRegWrite), 32'(exp_s.rw));
        chk("Misaligned",  32'(Misaligned),  32'(exp_s.mis));
        if (dknown) begin
            chk("OutALUResult", OutALUResult, exp_s.alu);
            chk("BranchTarget", BranchTarget, exp_s.target);
            chk("MemAddr",      MemAddr,      exp_s.addr);
            chk("OutMemSize",   32'(OutMemSize),  32'(exp_s.size));
            chk("OutWriteReg",  32'(OutWriteReg), 32'(exp_s.wreg));
        end
        if (wknown)
            chk("MemWData", MemWData, exp_s.wdata);
    endtask

    task automatic tick();
        model_edge();
        @(posedge Clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        Reset = 0; Stall = 0; Flush = 0; InValid = 1;
        ALUResult = 32'h0; Zero = 0; BranchType = 3'd0;
        PCPlus4 = 32'h0; SignExtImm = 32'h0; StoreData = 32'h0;
        MemWrite = 0; MemRead = 0; MemSize = 2'd0;
        RegWrite = 0; WriteReg = 5'd0;
    endtask

    task automatic rand_inputs();
        ALUResult  = $urandom;
        Zero       = 1'($urandom_range(0, 1));
        BranchType = 3'($urandom_range(0, 7));
        PCPlus4    = $urandom;
        SignExtImm = $urandom;
        StoreData  = $urandom;
        MemWrite   = 1'($urandom_range(0, 1));
        MemRead    = MemWrite ? 1'b0 : 1'($urandom_range(0, 1));
        MemSize    = 2'($urandom_range(0, 3));
        RegWrite   = 1'($urandom_range(0, 1));
        WriteReg   = 5'($urandom_range(0, 31));
    endtask

    initial begin
        idle();
        exp_s  = '{default: '0};
        dknown = 0;
        wknown = 0;

        rand_inputs();
        Reset = 1; Stall = 1;
        tick();
        chk("reset_valid", 32'(OutValid), 32'd0);

        idle();
        ALUResult = 32'h0000_0010;
        tick();
        chk("first_load_alu", OutALUResult, 32'h10);

        idle();
        BranchType = 3'd1; Zero = 1;
        PCPlus4 = 32'h100; SignExtImm = 32'hFFFF_FFFE;
        tick();
        chk("beq_target", BranchTarget, 32'hF8);
        chk("beq_taken", 32'(BranchTaken), 32'd1);
        BranchType = 3'd2;
        tick();
        chk("bne_taken", 32'(BranchTaken), 32'd0);
        BranchType = 3'd6; Zero = 0;
        tick();
        chk("bltz_taken", 32'(BranchTaken), 32'd1);
        BranchType = 3'd7;
        tick();
        chk("rsvd_taken", 32'(BranchTaken), 32'd0);

        idle();
        StoreData = 32'hAABB_CCDD; MemWrite = 1;
        MemSize = 2'd2; ALUResult = 32'h1003;
        tick();
        chk("sb_be", 32'(MemByteEn), 32'b1000);
        chk("sb_wdata", MemWData, 32'hDDDD_DDDD);
        chk("sb_addr", MemAddr, 32'h1000);
        MemSize = 2'd1; ALUResult = 32'h1002;
        tick();
        chk("sh_be", 32'(MemByteEn), 32'b1100);
        chk("sh_wdata", MemWData, 32'hCCDD_CCDD);
        MemSize = 2'd0; ALUResult = 32'h1004;
        tick();
        chk("sw_be", 32'(MemByteEn), 32'b1111);

        ALUResult = 32'h1002;
        tick();
        chk("sw_mis", 32'(Misaligned), 32'd1);
        chk("sw_mis_be", 32'(MemByteEn), 32'd0);
        MemWrite = 0; MemRead = 1; MemSize = 2'd1; ALUResult = 32'h1001;
        RegWrite = 1;
        tick();
        chk("lh_mis", 32'(Misaligned), 32'd1);
        chk("lh_mis_rd", 32'(OutMemRead), 32'd0);
        chk("lh_mis_rw", 32'(OutRegWrite), 32'd1);
        MemRead = 0; MemWrite = 1; MemSize = 2'd3; ALUResult = 32'h2000;
        tick();
        chk("size3_mis", 32'(Misaligned), 32'd1);

        idle();
        ALUResult = 32'hA0A0_A0A0; RegWrite = 1; WriteReg = 5'd7;
        tick();
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            Stall = 1;
            tick();
            chk("stall_hold", OutALUResult, 32'hA0A0_A0A0);
        end
        Stall = 1; Flush = 1;
        tick();
        chk("flush_valid", 32'(OutValid), 32'd0);
        idle();
        ALUResult = 32'hB0B0_B0B0; WriteReg = 5'd9; RegWrite = 1;
        tick();
        chk("load_b", OutALUResult, 32'hB0B0_B0B0);

        idle();
        InValid = 0; MemWrite = 1; RegWrite = 1;
        BranchType = 3'd1; Zero = 1;
        tick();
        chk("bubble_taken", 32'(BranchTaken), 32'd0);

        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            Reset   = ($urandom_range(0, 39) == 0);
            Flush   = ($urandom_range(0, 7) == 0);
            Stall   = ($urandom_range(0, 4) == 0);
            InValid = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
